// File: rtl/key_filter.sv
// key_filter: push-button debouncer and event decoder.
// A two-flop synchronizer feeds a four-state filter FSM. A level change is
// accepted only after it has held for DEBOUNCE_CYC consecutive cycles.
// Accepted presses and releases produce one-cycle pulses. A long-press pulse
// fires once per press after LONG_CYC cycles of accepted hold. An 8-bit
// counter of accepted presses wraps from 255 to 0.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   key_in      raw asynchronous key pin
//   key_state   debounced level, 1 = pressed
//   key_press   one-cycle pulse when a press is accepted
//   key_release one-cycle pulse when a release is accepted
//   long_press  one-cycle pulse, at most once per accepted press
//   press_cnt   count of accepted presses, wraps 255 -> 0
module key_filter #(
  parameter int   DEBOUNCE_CYC = 1_000_000,
  parameter int   LONG_CYC     = 50_000_000,
  parameter logic KEY_ACTIVE   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic       key_state,
  output logic       key_press,
  output logic       key_release,
  output logic       long_press,
  output logic [7:0] press_cnt
);

  localparam logic [25:0] DC_MAX = 26'(DEBOUNCE_CYC - 1);
  localparam logic [25:0] LC_MAX = 26'(LONG_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILT_DN,
    DOWN,
    FILT_UP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_s1;
  logic        r_s2;
  logic [25:0] r_dcnt;
  logic [25:0] w_dcnt_nxt;
  logic [25:0] r_lcnt;
  logic [25:0] w_lcnt_nxt;
  logic        r_flag;
  logic        w_flag_nxt;
  logic        w_state_out_nxt;
  logic        w_press_nxt;
  logic        w_release_nxt;
  logic        w_long_nxt;
  logic [7:0]  w_cnt_nxt;
  logic        w_p;
  logic [25:0] w_lcnt_run;
  logic        w_long_hit;

  assign w_p        = (r_s2 == KEY_ACTIVE);
  // Hold counter saturates so the long-press compare stays true afterwards;
  // the flag keeps it from firing again.
  assign w_lcnt_run = (r_lcnt != LC_MAX) ? r_lcnt + 26'd1 : r_lcnt;
  assign w_long_hit = (r_lcnt == LC_MAX) && !r_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1        <= ~KEY_ACTIVE;
      r_s2        <= ~KEY_ACTIVE;
      r_state     <= IDLE;
      r_dcnt      <= '0;
      r_lcnt      <= '0;
      r_flag      <= 1'b0;
      key_state   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      long_press  <= 1'b0;
      press_cnt   <= '0;
    end else begin
      r_s1        <= key_in;
      r_s2        <= r_s1;
      r_state     <= w_state_nxt;
      r_dcnt      <= w_dcnt_nxt;
      r_lcnt      <= w_lcnt_nxt;
      r_flag      <= w_flag_nxt;
      key_state   <= w_state_out_nxt;
      key_press   <= w_press_nxt;
      key_release <= w_release_nxt;
      long_press  <= w_long_nxt;
      press_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_dcnt_nxt      = r_dcnt;
    w_lcnt_nxt      = r_lcnt;
    w_flag_nxt      = r_flag;
    w_state_out_nxt = key_state;
    w_press_nxt     = 1'b0;
    w_release_nxt   = 1'b0;
    w_long_nxt      = 1'b0;
    w_cnt_nxt       = press_cnt;

    case (r_state)
      IDLE: begin
        w_dcnt_nxt = '0;
        if (w_p) begin
          w_state_nxt = FILT_DN;
        end
      end

      FILT_DN: begin
        if (!w_p) begin
          w_state_nxt = IDLE;
          w_dcnt_nxt  = '0;
        end else if (r_dcnt == DC_MAX) begin
          w_state_nxt     = DOWN;
          w_press_nxt     = 1'b1;
          w_state_out_nxt = 1'b1;
          w_cnt_nxt       = press_cnt + 8'd1;
          w_dcnt_nxt      = '0;
          w_lcnt_nxt      = '0;
          w_flag_nxt      = 1'b0;
        end else begin
          w_dcnt_nxt = r_dcnt + 26'd1;
        end
      end

      DOWN: begin
        w_dcnt_nxt = '0;
        w_lcnt_nxt = w_lcnt_run;
        if (w_long_hit) begin
          w_long_nxt = 1'b1;
          w_flag_nxt = 1'b1;
        end
        if (!w_p) begin
          w_state_nxt = FILT_UP;
        end
      end

      FILT_UP: begin
        w_lcnt_nxt = w_lcnt_run;
        if (w_p) begin
          w_state_nxt = DOWN;
          w_dcnt_nxt  = '0;
        end else if (r_dcnt == DC_MAX) begin
          w_state_nxt     = IDLE;
          w_release_nxt   = 1'b1;
          w_state_out_nxt = 1'b0;
          w_dcnt_nxt      = '0;
        end else begin
          w_dcnt_nxt = r_dcnt + 26'd1;
        end
        // An accepted release wins over a long press landing on the same edge.
        if (w_long_hit && !w_release_nxt) begin
          w_long_nxt = 1'b1;
          w_flag_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_key_filter.sv
// tb_key_filter: self-checking bench for key_filter with a run-length
// reference model of the debounce, long-press and press-count behaviour.
module tb_key_filter;

  localparam int   DEB = 8;
  localparam int   LNG = 32;
  localparam logic ACT = 1'b0;

  logic       clk;
  logic       rst;
  logic       key_in;
  logic       key_state;
  logic       key_press;
  logic       key_release;
  logic       long_press;
  logic [7:0] press_cnt;

  key_filter #(
    .DEBOUNCE_CYC(DEB),
    .LONG_CYC    (LNG),
    .KEY_ACTIVE  (ACT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .long_press (long_press),
    .press_cnt  (press_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: pressed-level samples delayed two edges, a run length
  // of consecutive samples disagreeing with the accepted level, and the
  // number of edges spent pressed since acceptance.
  bit m_s1, m_s2, m_acc;
  int m_run, m_cnt, m_held;
  bit e_press, e_rel, e_long;
  int press_pulses = 0;

  task automatic model(input logic k, input logic r);
    bit p, prev;
    e_press = 0; e_rel = 0; e_long = 0;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_acc = 0; m_run = 0; m_cnt = 0; m_held = 0;
    end else begin
      p    = m_s2;
      m_s2 = m_s1;
      m_s1 = (k == ACT);
      prev = m_acc;
      if (p != m_acc) m_run++;
      else m_run = 0;
      if (m_run == DEB + 1) begin
        m_acc = !m_acc;
        m_run = 0;
        if (m_acc) begin
          e_press = 1;
          m_cnt   = (m_cnt + 1) % 256;
          m_held  = 0;
        end else begin
          e_rel = 1;
        end
      end
      if (prev) begin
        m_held++;
        if (m_held == LNG && !e_rel) e_long = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input logic k, input logic r);
    key_in = k;
    rst    = r;
    @(posedge clk);
    model(k, r);
    #1;
    chk("key_state",   {7'd0, key_state},   {7'd0, m_acc});
    chk("key_press",   {7'd0, key_press},   {7'd0, e_press});
    chk("key_release", {7'd0, key_release}, {7'd0, e_rel});
    chk("long_press",  {7'd0, long_press},  {7'd0, e_long});
    chk("press_cnt",   press_cnt,           8'(m_cnt));
    chk("press_and_release_exclusive", {7'd0, key_press & key_release}, 8'd0);
    if (key_press === 1'b1) press_pulses++;
  endtask

  task automatic hold(input logic k, input int n);
    for (int i = 0; i < n; i++) tick(k, 1'b0);
  endtask

  int start_pulses;
  int seg_len;
  logic lvl;

  initial begin
    key_in = 1'b0;
    rst    = 1'b1;
    // Reset with key held pressed, then the press is seen afresh.
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    hold(1'b0, 20);
    hold(1'b1, 20);

    // Clean press and release.
    hold(1'b0, 20);
    hold(1'b1, 20);

    // Bounce on press then on release.
    for (int i = 0; i < 10; i++) hold(i[0], 3);
    hold(1'b0, 20);
    for (int i = 0; i < 10; i++) hold(~i[0], 3);
    hold(1'b1, 20);

    // Long press with a short release bounce.
    hold(1'b0, 100);
    hold(1'b1, 2);
    hold(1'b0, 1);
    hold(1'b1, 2);
    hold(1'b1, 20);

    // Release landing right around the long-press boundary.
    for (int j = 0; j < 4; j++) begin
      hold(1'b0, 10 + LNG - 2 + j);
      hold(1'b1, 20);
    end

    // Random segments.
    for (int i = 0; i < 60; i++) begin
      lvl     = 1'($urandom_range(0, 1));
      seg_len = int'($urandom_range(1, 15));
      hold(lvl, seg_len);
    end
    hold(1'b1, 20);

    // Wrap of the press counter.
    start_pulses = press_pulses;
    for (int i = 0; i < 256; i++) begin
      hold(1'b0, 12);
      hold(1'b1, 12);
    end
    chk("wrap_pulses", 8'(press_pulses - start_pulses == 256), 8'd1);

    // Reset while held down, key stays pressed through and after reset.
    hold(1'b0, 20);
    tick(1'b0, 1'b1);
    hold(1'b0, 15);
    chk("after_reset_cnt", press_cnt, 8'd1);
    hold(1'b1, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
